// File: rtl/dot11_rx_supervisor_if.sv
// Status, handshake and result signals between the dot11 receive core and its
// frame-level supervisor.
interface dot11_rx_supervisor_if;
  logic        enable;
  logic        sample_in_strobe;
  logic        power_trigger;
  logic        short_preamble_detected;
  logic        long_preamble_detected;
  logic        legacy_sig_stb;
  logic [3:0]  legacy_rate;
  logic        legacy_sig_rsvd;
  logic [11:0] legacy_len;
  logic        legacy_sig_parity;
  logic [5:0]  legacy_sig_tail;
  logic        byte_out_strobe;
  logic        core_reset;
  logic [2:0]  sup_state;
  logic        pkt_start;
  logic        pkt_done;
  logic        pkt_err;
  logic [2:0]  err_code;
  logic [11:0] pkt_len;
  logic [11:0] byte_count;

  modport master (
    output enable, sample_in_strobe, power_trigger, short_preamble_detected,
           long_preamble_detected, legacy_sig_stb, legacy_rate, legacy_sig_rsvd,
           legacy_len, legacy_sig_parity, legacy_sig_tail, byte_out_strobe,
    input  core_reset, sup_state, pkt_start, pkt_done, pkt_err, err_code,
           pkt_len, byte_count
  );

  modport slave (
    input  enable, sample_in_strobe, power_trigger, short_preamble_detected,
           long_preamble_detected, legacy_sig_stb, legacy_rate, legacy_sig_rsvd,
           legacy_len, legacy_sig_parity, legacy_sig_tail, byte_out_strobe,
    output core_reset, sup_state, pkt_start, pkt_done, pkt_err, err_code,
           pkt_len, byte_count
  );
endinterface

// File: rtl/dot11_rx_supervisor.sv
// Frame-level receive supervisor: tracks preamble/SIGNAL/DATA progress, validates
// the legacy SIGNAL field, runs sample watchdogs and re-arms the core after each packet.
module dot11_rx_supervisor #(
  parameter int unsigned LONG_TIMEOUT = 320,
  parameter int unsigned SIG_TIMEOUT  = 160,
  parameter int unsigned BYTE_TIMEOUT = 400,
  parameter int unsigned MIN_LEN      = 14,
  parameter int unsigned MAX_LEN      = 4095,
  parameter int unsigned RST_CYCLES   = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  dot11_rx_supervisor_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LONG = 3'd1,
    ST_WAIT_SIG  = 3'd2,
    ST_DATA      = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERR       = 3'd5,
    ST_RECOVER   = 3'd6
  } state_e;

  localparam int unsigned RCW        = $clog2(RST_CYCLES + 1);
  localparam logic [15:0] LONG_TO    = 16'(LONG_TIMEOUT);
  localparam logic [15:0] SIG_TO     = 16'(SIG_TIMEOUT);
  localparam logic [15:0] BYTE_TO    = 16'(BYTE_TIMEOUT);
  localparam logic [11:0] MIN_LEN_W  = 12'(MIN_LEN);
  localparam logic [11:0] MAX_LEN_W  = 12'(MAX_LEN);
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  localparam logic [2:0] E_LONG_TO = 3'd1;
  localparam logic [2:0] E_SIG_TO  = 3'd2;
  localparam logic [2:0] E_BYTE_TO = 3'd7;

  // First failing SIGNAL check in priority order; zero when the field is acceptable.
  function automatic logic [2:0] sig_check(
    input logic [3:0]  rate,
    input logic        rsvd,
    input logic [11:0] len,
    input logic        par,
    input logic [5:0]  tail
  );
    logic [2:0] code;
    code = 3'd0;
    if (^{rate, rsvd, len, par}) begin
      code = 3'd3;
    end else if (!rate[3]) begin
      code = 3'd4;
    end else if (rsvd || (tail != 6'd0)) begin
      code = 3'd5;
    end else if ((len < MIN_LEN_W) || (len > MAX_LEN_W)) begin
      code = 3'd6;
    end else begin
      code = 3'd0;
    end
    return code;
  endfunction

  state_e         state_q, state_d;
  logic [15:0]    timer_q, timer_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic [11:0]    byte_count_q, byte_count_d;
  logic [11:0]    pkt_len_q, pkt_len_d;
  logic [2:0]     err_code_q, err_code_d;
  logic [2:0]     err_pend_q, err_pend_d;
  logic           pkt_start_q, pkt_start_d;
  logic           pkt_done_q, pkt_done_d;
  logic           pkt_err_q, pkt_err_d;
  logic           core_reset_q, core_reset_d;

  logic [2:0]     sig_code_s;
  logic [11:0]    bc_inc_s;
  logic [15:0]    timer_inc_s;
  logic           byte_clr_s;

  assign sig_code_s  = sig_check(bus.legacy_rate, bus.legacy_sig_rsvd, bus.legacy_len,
                                 bus.legacy_sig_parity, bus.legacy_sig_tail);
  assign bc_inc_s    = (byte_count_q == 12'hFFF) ? 12'hFFF : byte_count_q + 12'd1;
  assign timer_inc_s = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

  // Next-state, watchdog and packet bookkeeping logic.
  always_comb begin
    state_d      = state_q;
    rcnt_d       = '0;
    byte_count_d = byte_count_q;
    pkt_len_d    = pkt_len_q;
    err_code_d   = err_code_q;
    err_pend_d   = err_pend_q;
    byte_clr_s   = 1'b0;

    // RECOVER always runs to completion so the core sees a full reset pulse.
    if (!bus.enable && (state_q != ST_RECOVER)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.short_preamble_detected && bus.power_trigger) begin
            state_d = ST_WAIT_LONG;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT_LONG: begin
          if (bus.long_preamble_detected) begin
            state_d = ST_WAIT_SIG;
          end else if (timer_q >= LONG_TO) begin
            state_d    = ST_ERR;
            err_pend_d = E_LONG_TO;
          end else begin
            state_d = ST_WAIT_LONG;
          end
        end
        ST_WAIT_SIG: begin
          if (bus.legacy_sig_stb) begin
            if (sig_code_s != 3'd0) begin
              state_d    = ST_ERR;
              err_pend_d = sig_code_s;
            end else begin
              state_d      = ST_DATA;
              pkt_len_d    = bus.legacy_len;
              byte_count_d = 12'd0;
              err_code_d   = 3'd0;
            end
          end else if (timer_q >= SIG_TO) begin
            state_d    = ST_ERR;
            err_pend_d = E_SIG_TO;
          end else begin
            state_d = ST_WAIT_SIG;
          end
        end
        ST_DATA: begin
          if (bus.byte_out_strobe) begin
            byte_clr_s   = 1'b1;
            byte_count_d = bc_inc_s;
            if (bc_inc_s == pkt_len_q) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_DATA;
            end
          end else if (timer_q >= BYTE_TO) begin
            state_d    = ST_ERR;
            err_pend_d = E_BYTE_TO;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DONE: begin
          state_d = ST_RECOVER;
        end
        ST_ERR: begin
          state_d    = ST_RECOVER;
          err_code_d = err_pend_q;
        end
        ST_RECOVER: begin
          if (rcnt_q == RST_LAST) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RECOVER;
            rcnt_d  = rcnt_q + RCW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (!bus.enable || (state_d != state_q) || byte_clr_s) begin
      timer_d = 16'd0;
    end else if (bus.sample_in_strobe) begin
      timer_d = timer_inc_s;
    end else begin
      timer_d = timer_q;
    end

    pkt_start_d  = (state_q == ST_WAIT_SIG) && (state_d == ST_DATA);
    pkt_done_d   = (state_d == ST_DONE);
    pkt_err_d    = (state_q == ST_ERR) && (state_d == ST_RECOVER);
    core_reset_d = (state_d == ST_RECOVER);
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= 16'd0;
      rcnt_q       <= '0;
      byte_count_q <= 12'd0;
      pkt_len_q    <= 12'd0;
      err_code_q   <= 3'd0;
      err_pend_q   <= 3'd0;
      pkt_start_q  <= 1'b0;
      pkt_done_q   <= 1'b0;
      pkt_err_q    <= 1'b0;
      core_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      rcnt_q       <= rcnt_d;
      byte_count_q <= byte_count_d;
      pkt_len_q    <= pkt_len_d;
      err_code_q   <= err_code_d;
      err_pend_q   <= err_pend_d;
      pkt_start_q  <= pkt_start_d;
      pkt_done_q   <= pkt_done_d;
      pkt_err_q    <= pkt_err_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign bus.core_reset = core_reset_q;
  assign bus.sup_state  = state_q;
  assign bus.pkt_start  = pkt_start_q;
  assign bus.pkt_done   = pkt_done_q;
  assign bus.pkt_err    = pkt_err_q;
  assign bus.err_code   = err_code_q;
  assign bus.pkt_len    = pkt_len_q;
  assign bus.byte_count = byte_count_q;

endmodule

// File: tb/tb_dot11_rx_supervisor.sv
// Self-checking bench for dot11_rx_supervisor: directed scenarios plus randomized
// SIGNAL fields judged by a rule-level reference model.
module tb_dot11_rx_supervisor;
  logic clock = 1'b0;
  logic reset = 1'b1;

  dot11_rx_supervisor_if ifc();

  dot11_rx_supervisor dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int n_start = 0, n_done = 0, n_err = 0;
  int rst_run = 0, last_run = 0;
  int exp_bc = 0;

  // Pulse counters and core_reset run-length measurement.
  always @(negedge clock) begin
    if (ifc.pkt_start === 1'b1) n_start <= n_start + 1;
    if (ifc.pkt_done === 1'b1) n_done <= n_done + 1;
    if (ifc.pkt_err === 1'b1) n_err <= n_err + 1;
    if (ifc.core_reset === 1'b1) rst_run <= rst_run + 1;
    else if (rst_run != 0) begin
      last_run <= rst_run;
      rst_run  <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rules for the SIGNAL field, written from the field definitions.
  function automatic int exp_code(input logic [3:0] rate, input logic rsvd,
                                  input logic [11:0] len, input logic par,
                                  input logic [5:0] tail);
    int ones;
    ones = $countones({rate, rsvd, len, par});
    if ((ones % 2) != 0) return 3;
    if (rate < 4'd8) return 4;
    if (rsvd != 1'b0 || tail != 6'd0) return 5;
    if (int'(len) < 14 || int'(len) > 4095) return 6;
    return 0;
  endfunction

  function automatic logic even_par(input logic [3:0] rate, input logic rsvd,
                                    input logic [11:0] len);
    return logic'(($countones({rate, rsvd, len}) % 2) != 0);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic samples(input int n);
    for (int i = 0; i < n; i++) begin
      ifc.sample_in_strobe = 1'b1;
      tick();
      ifc.sample_in_strobe = 1'b0;
      tick();
    end
  endtask

  task automatic send_byte();
    ifc.byte_out_strobe = 1'b1;
    tick();
    ifc.byte_out_strobe = 1'b0;
  endtask

  task automatic send_sig(input logic [3:0] rate, input logic rsvd, input logic [11:0] len,
                          input logic par, input logic [5:0] tail);
    ifc.legacy_rate       = rate;
    ifc.legacy_sig_rsvd   = rsvd;
    ifc.legacy_len        = len;
    ifc.legacy_sig_parity = par;
    ifc.legacy_sig_tail   = tail;
    ifc.legacy_sig_stb    = 1'b1;
    tick();
    ifc.legacy_sig_stb    = 1'b0;
  endtask

  task automatic start_to_sig(input int long_at);
    ifc.short_preamble_detected = 1'b1;
    ifc.power_trigger = 1'b1;
    tick();
    ifc.short_preamble_detected = 1'b0;
    samples(long_at);
    ifc.long_preamble_detected = 1'b1;
    tick();
    ifc.long_preamble_detected = 1'b0;
    check("in_wait_sig", ifc.sup_state, 2);
    samples(2);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (ifc.sup_state !== 3'd0 && k < 100) begin
      tick();
      k++;
    end
    check("idle_return_bound", k < 100, 1);
    tick();
    check("core_reset_len", last_run, 8);
  endtask

  // Sends a SIGNAL field and checks the accept/abort response against the model.
  task automatic sig_and_check(input logic [3:0] rate, input logic rsvd, input logic [11:0] len,
                               input logic par, input logic [5:0] tail, output int code);
    int s0;
    s0 = n_start;
    code = exp_code(rate, rsvd, len, par, tail);
    send_sig(rate, rsvd, len, par, tail);
    if (code == 0) begin
      check("pkt_start", ifc.pkt_start, 1);
      check("state_data", ifc.sup_state, 3);
      check("err_code_clr", ifc.err_code, 0);
      check("pkt_len", ifc.pkt_len, len);
    end else begin
      check("no_start", ifc.pkt_start, 0);
      check("state_err", ifc.sup_state, 5);
      tick();
      check("pkt_err", ifc.pkt_err, 1);
      check("err_code", ifc.err_code, code);
      check("err_core_reset", ifc.core_reset, 1);
      check("no_start_count", n_start - s0, 0);
    end
  endtask

  task automatic finish_good(input int len);
    check("pkt_done", ifc.pkt_done, 1);
    check("byte_count", ifc.byte_count, len);
    check("state_done", ifc.sup_state, 4);
    tick();
    check("done_pulse_end", ifc.pkt_done, 0);
    check("done_core_reset", ifc.core_reset, 1);
    wait_idle();
  endtask

  initial begin
    int code;
    int s0, d0, e0, kind, gap, len;
    logic [3:0] rate;
    logic [5:0] tail;
    logic par;

    ifc.enable = 1'b1;
    ifc.sample_in_strobe = 1'b0;
    ifc.power_trigger = 1'b0;
    ifc.short_preamble_detected = 1'b0;
    ifc.long_preamble_detected = 1'b0;
    ifc.legacy_sig_stb = 1'b0;
    ifc.legacy_rate = 4'd0;
    ifc.legacy_sig_rsvd = 1'b0;
    ifc.legacy_len = 12'd0;
    ifc.legacy_sig_parity = 1'b0;
    ifc.legacy_sig_tail = 6'd0;
    ifc.byte_out_strobe = 1'b0;

    repeat (3) tick();
    check("reset_ctrl", {ifc.sup_state, ifc.core_reset, ifc.pkt_start, ifc.pkt_done,
                         ifc.pkt_err, ifc.err_code}, 0);
    check("reset_counts", {ifc.pkt_len, ifc.byte_count}, 0);
    reset = 1'b0;
    tick();

    // Strobes outside their state are ignored.
    send_byte();
    send_sig(4'b1011, 1'b0, 12'd20, even_par(4'b1011, 1'b0, 12'd20), 6'd0);
    check("idle_ignore_state", ifc.sup_state, 0);
    check("idle_ignore_bc", ifc.byte_count, 0);
    check("idle_ignore_start", ifc.pkt_start, 0);

    // Good packet: long at sample 100, len 20, bytes 80 samples apart.
    s0 = n_start; d0 = n_done;
    start_to_sig(100);
    sig_and_check(4'b1011, 1'b0, 12'd20, even_par(4'b1011, 1'b0, 12'd20), 6'd0, code);
    for (int i = 0; i < 20; i++) begin
      samples(80);
      send_byte();
    end
    finish_good(20);
    check("good_start_once", n_start - s0, 1);
    check("good_done_once", n_done - d0, 1);
    exp_bc = 20;

    // Parity error.
    start_to_sig(3);
    sig_and_check(4'b1011, 1'b0, 12'd100, ~even_par(4'b1011, 1'b0, 12'd100), 6'd0, code);
    check("parity_code_model", code, 3);
    wait_idle();

    // Rate fault outranks format fault.
    start_to_sig(3);
    sig_and_check(4'b0011, 1'b0, 12'd20, even_par(4'b0011, 1'b0, 12'd20), 6'd1, code);
    wait_idle();

    // Long-preamble timeout.
    e0 = n_err;
    ifc.short_preamble_detected = 1'b1;
    tick();
    ifc.short_preamble_detected = 1'b0;
    samples(319);
    check("long_wait_319", ifc.sup_state, 1);
    samples(1);
    check("long_timeout_state", ifc.sup_state, 5);
    tick();
    check("long_timeout_code", ifc.err_code, 1);
    wait_idle();
    check("long_timeout_errs", n_err - e0, 1);

    // Long preamble coinciding with the timeout condition wins.
    ifc.short_preamble_detected = 1'b1;
    tick();
    ifc.short_preamble_detected = 1'b0;
    samples(319);
    ifc.sample_in_strobe = 1'b1;
    tick();
    ifc.sample_in_strobe = 1'b0;
    ifc.long_preamble_detected = 1'b1;
    tick();
    ifc.long_preamble_detected = 1'b0;
    check("long_at_320", ifc.sup_state, 2);
    check("long_at_320_noerr", ifc.pkt_err, 0);

    // SIGNAL timeout from the same packet.
    samples(159);
    check("sig_wait_159", ifc.sup_state, 2);
    samples(1);
    check("sig_timeout_state", ifc.sup_state, 5);
    tick();
    check("sig_timeout_code", ifc.err_code, 2);
    wait_idle();

    // Data stall after 10 of 50 bytes.
    start_to_sig(3);
    sig_and_check(4'b1101, 1'b0, 12'd50, even_par(4'b1101, 1'b0, 12'd50), 6'd0, code);
    for (int i = 0; i < 10; i++) begin
      samples(3);
      send_byte();
    end
    samples(399);
    check("stall_399", ifc.sup_state, 3);
    samples(1);
    check("stall_state", ifc.sup_state, 5);
    tick();
    check("stall_code", ifc.err_code, 7);
    check("stall_bc", ifc.byte_count, 10);
    wait_idle();
    exp_bc = 10;

    // Randomized SIGNAL fields and byte spacing.
    for (int p = 0; p < 10; p++) begin
      kind = int'($urandom_range(0, 4));
      rate = {1'b1, 3'($urandom_range(0, 7))};
      tail = 6'd0;
      len  = int'($urandom_range(14, 30));
      if (kind == 2) rate[3] = 1'b0;
      if (kind == 3) tail = 6'($urandom_range(1, 63));
      if (kind == 4) len = int'($urandom_range(0, 13));
      par = even_par(rate, 1'b0, 12'(len));
      if (kind == 1) par = ~par;
      start_to_sig(int'($urandom_range(1, 20)));
      sig_and_check(rate, 1'b0, 12'(len), par, tail, code);
      if (code == 0) begin
        for (int i = 0; i < len; i++) begin
          gap = int'($urandom_range(0, 6));
          samples(gap);
          send_byte();
        end
        finish_good(len);
        exp_bc = len;
      end else begin
        check("rand_err_bc_kept", ifc.byte_count, exp_bc);
        wait_idle();
      end
    end

    // Asynchronous reset during DATA at byte 5.
    start_to_sig(3);
    sig_and_check(4'b1011, 1'b0, 12'd30, even_par(4'b1011, 1'b0, 12'd30), 6'd0, code);
    for (int i = 0; i < 5; i++) begin
      samples(2);
      send_byte();
    end
    check("pre_reset_bc", ifc.byte_count, 5);
    #2 reset = 1'b1;
    #1;
    check("async_reset_ctrl", {ifc.sup_state, ifc.core_reset, ifc.pkt_start, ifc.pkt_done,
                               ifc.pkt_err, ifc.err_code}, 0);
    check("async_reset_counts", {ifc.pkt_len, ifc.byte_count}, 0);
    tick();
    reset = 1'b0;
    tick();

    // Enable drop in WAIT_SIG; later SIGNAL strobes are ignored.
    start_to_sig(3);
    ifc.enable = 1'b0;
    tick();
    check("enable_drop_state", ifc.sup_state, 0);
    send_sig(4'b1011, 1'b0, 12'd20, even_par(4'b1011, 1'b0, 12'd20), 6'd0);
    check("enable_low_sig_state", ifc.sup_state, 0);
    check("enable_low_no_start", ifc.pkt_start, 0);
    check("enable_low_no_reset", ifc.core_reset, 0);
    ifc.enable = 1'b1;
    tick();
    send_sig(4'b0011, 1'b0, 12'd20, 1'b0, 6'd0);
    tick();
    check("late_sig_state", ifc.sup_state, 0);
    check("late_sig_err_code", ifc.err_code, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
